// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side signal bundle for data_mem_arbiter.
// The arbiter connects through the slave modport; requesters and the memory use master.
interface data_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_ready;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_ready;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_result;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_result,
        output r0_ready, r0_rdata, r1_ready, r1_rdata,
        output mem_read, mem_write, mem_address, mem_data
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_result,
        input  r0_ready, r0_rdata, r1_ready, r1_rdata,
        input  mem_read, mem_write, mem_address, mem_data
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-requester arbiter and fixed-latency access sequencer for the
// single-port data memory. Every output, including memory control, is registered.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e             state_q;
    logic               prio_q;
    logic               gnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cmd_we_q;
    logic               r0_ready_q;
    logic               r1_ready_q;
    logic [DATA_W-1:0]  r0_rdata_q;
    logic [DATA_W-1:0]  r1_rdata_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic [ADDR_W-1:0]  mem_address_q;
    logic [DATA_W-1:0]  mem_data_q;

    // Requester 1 wins only if it asks alone or holds the priority pointer.
    logic               grant_r1_c;
    logic               sel_we_c;
    logic [ADDR_W-1:0]  sel_addr_c;
    logic [DATA_W-1:0]  sel_wdata_c;

    assign grant_r1_c  = bus.r1_req && (!bus.r0_req || prio_q);
    assign sel_we_c    = grant_r1_c ? bus.r1_we    : bus.r0_we;
    assign sel_addr_c  = grant_r1_c ? bus.r1_addr  : bus.r0_addr;
    assign sel_wdata_c = grant_r1_c ? bus.r1_wdata : bus.r0_wdata;

    // mem_address_q/mem_data_q double as the command address/data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            gnt_q         <= 1'b0;
            cnt_q         <= '0;
            cmd_we_q      <= 1'b0;
            r0_ready_q    <= 1'b0;
            r1_ready_q    <= 1'b0;
            r0_rdata_q    <= '0;
            r1_rdata_q    <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
        end else begin
            r0_ready_q  <= 1'b0;
            r1_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.r0_req || bus.r1_req) begin
                        gnt_q         <= grant_r1_c;
                        prio_q        <= !grant_r1_c;
                        cmd_we_q      <= sel_we_c;
                        mem_address_q <= sel_addr_c;
                        mem_data_q    <= sel_wdata_c;
                        cnt_q         <= CNT_W'(WAIT_CYCLES);
                        mem_read_q    <= !sel_we_c;
                        // With no wait states the first ACCESS cycle is also the last.
                        mem_write_q   <= sel_we_c && (WAIT_CYCLES == 0);
                        state_q       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        mem_read_q <= 1'b0;
                        if (!cmd_we_q) begin
                            if (gnt_q) r1_rdata_q <= bus.mem_result;
                            else       r0_rdata_q <= bus.mem_result;
                        end
                        r0_ready_q <= !gnt_q;
                        r1_ready_q <= gnt_q;
                        state_q    <= RESP;
                    end else begin
                        cnt_q       <= cnt_q - CNT_W'(1);
                        mem_write_q <= cmd_we_q && (cnt_q == CNT_W'(1));
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.r0_ready    = r0_ready_q;
    assign bus.r1_ready    = r1_ready_q;
    assign bus.r0_rdata    = r0_rdata_q;
    assign bus.r1_rdata    = r1_rdata_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: three instances (1, 3 and 2 wait states) sharing one clock,
// each with its own behavioural memory; results are checked against a transaction-level model.
module tb_data_mem_arbiter;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned WA = 1;
    localparam int unsigned WB = 3;
    localparam int unsigned WC = 2;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();
    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WA)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WB)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));
    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

    // Behavioural single-port memories: combinational read, write on the clock edge.
    logic [DW-1:0] mem_a [64] = '{default: '0};
    logic [DW-1:0] mem_b [64] = '{default: '0};
    logic [DW-1:0] mem_c [64] = '{default: '0};
    assign ifa.mem_result = mem_a[ifa.mem_address];
    assign ifb.mem_result = mem_b[ifb.mem_address];
    assign ifc.mem_result = mem_c[ifc.mem_address];
    always @(posedge clk) if (ifa.mem_write) mem_a[ifa.mem_address] <= ifa.mem_data;
    always @(posedge clk) if (ifb.mem_write) mem_b[ifb.mem_address] <= ifb.mem_data;
    always @(posedge clk) if (ifc.mem_write) mem_c[ifc.mem_address] <= ifc.mem_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference model for instance a.
    logic [DW-1:0] exp_mem [64] = '{default: '0};
    logic [DW-1:0] exp_rd  [2];
    int            m_prio;

    task automatic model_a(input int r, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (we) exp_mem[addr] = wdata;
        else    exp_rd[r]     = exp_mem[addr];
        m_prio = 1 - r;
    endtask

    task automatic model_reset_a();
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        m_prio    = 0;
    endtask

    // Observations gathered by run_a for the calling test to compare.
    int            obs_ready_n, obs_ready_cnt, obs_other_cnt, obs_wr_cnt, obs_wr_n, obs_rd_cnt;
    logic [AW-1:0] obs_wr_addr;
    logic [DW-1:0] obs_rdata, obs_other_rdata;

    task automatic drive_req_a(input int r, input logic v);
        if (r == 0) ifa.r0_req = v;
        else        ifa.r1_req = v;
    endtask

    // Issue one lone transaction on instance a; optionally drop req early at cycle drop_n.
    task automatic run_a(input int r, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int drop_n);
        if (r == 0) begin ifa.r0_we = we; ifa.r0_addr = addr; ifa.r0_wdata = wdata; end
        else        begin ifa.r1_we = we; ifa.r1_addr = addr; ifa.r1_wdata = wdata; end
        drive_req_a(r, 1'b1);
        obs_ready_n = -1; obs_ready_cnt = 0; obs_other_cnt = 0;
        obs_wr_cnt = 0; obs_wr_n = -1; obs_rd_cnt = 0; obs_wr_addr = '0;
        for (int n = 1; n <= int'(WA) + 4; n++) begin
            @(negedge clk);
            if (n == drop_n) drive_req_a(r, 1'b0);
            if ((r == 0) ? ifa.r0_ready : ifa.r1_ready) begin
                obs_ready_cnt++;
                obs_ready_n = n;
                drive_req_a(r, 1'b0);
            end
            if ((r == 0) ? ifa.r1_ready : ifa.r0_ready) obs_other_cnt++;
            if (ifa.mem_write) begin obs_wr_cnt++; obs_wr_n = n; obs_wr_addr = ifa.mem_address; end
            if (ifa.mem_read) obs_rd_cnt++;
        end
        obs_rdata       = (r == 0) ? ifa.r0_rdata : ifa.r1_rdata;
        obs_other_rdata = (r == 0) ? ifa.r1_rdata : ifa.r0_rdata;
    endtask

    function automatic logic [2*DW+2*AW-1:0] outs_a();
        return {ifa.r0_rdata, ifa.r1_rdata, ifa.mem_address, 2'b00} |
               {(2*DW+2*AW)'(ifa.mem_data) << AW, 4'b0000} |
               (2*DW+2*AW)'({ifa.r0_ready, ifa.r1_ready, ifa.mem_read, ifa.mem_write});
    endfunction

    task automatic test_reset_values();
        #1;
        n_tests++;
        if ({ifa.r0_ready, ifa.r1_ready, ifa.mem_read, ifa.mem_write} !== 4'b0000 ||
            ifa.mem_address !== '0 || ifa.mem_data !== '0 || ifa.r0_rdata !== '0 || ifa.r1_rdata !== '0) begin
            n_fail++; $display("FAIL reset_values: outputs not all zero (rdata0=%h rdata1=%h addr=%0d)",
                               ifa.r0_rdata, ifa.r1_rdata, ifa.mem_address);
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        run_a(0, 1'b1, 6'd12, 32'hDEADBEEF, 0);
        model_a(0, 1'b1, 6'd12, 32'hDEADBEEF);
        n_tests++; if (obs_ready_n !== int'(WA) + 2) begin n_fail++; $display("FAIL wr_ready_cycle: got %0d exp %0d", obs_ready_n, WA + 2); end
        n_tests++; if (obs_wr_cnt !== 1) begin n_fail++; $display("FAIL wr_pulse_count: got %0d exp 1", obs_wr_cnt); end
        n_tests++; if (obs_wr_n !== int'(WA) + 1) begin n_fail++; $display("FAIL wr_pulse_cycle: got %0d exp %0d", obs_wr_n, WA + 1); end
        n_tests++; if (obs_wr_addr !== 6'd12) begin n_fail++; $display("FAIL wr_addr: got %0d exp 12", obs_wr_addr); end
        n_tests++; if (mem_a[12] !== exp_mem[12]) begin n_fail++; $display("FAIL wr_commit: got %h exp %h", mem_a[12], exp_mem[12]); end
        run_a(0, 1'b0, 6'd12, 32'h0, 0);
        model_a(0, 1'b0, 6'd12, 32'h0);
        n_tests++; if (obs_rd_cnt !== int'(WA) + 1) begin n_fail++; $display("FAIL rd_read_cycles: got %0d exp %0d", obs_rd_cnt, WA + 1); end
        n_tests++; if (obs_wr_cnt !== 0) begin n_fail++; $display("FAIL rd_no_write: got %0d exp 0", obs_wr_cnt); end
        n_tests++; if (obs_rdata !== exp_rd[0]) begin n_fail++; $display("FAIL rd_data: got %h exp %h", obs_rdata, exp_rd[0]); end
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        model_reset_a();
        #1;
        n_tests++;
        if ({ifa.r0_ready, ifa.r1_ready, ifa.mem_read, ifa.mem_write} !== 4'b0000 ||
            ifa.mem_address !== '0 || ifa.mem_data !== '0 || ifa.r0_rdata !== '0 || ifa.r1_rdata !== '0) begin
            n_fail++; $display("FAIL midsim_reset_outputs: rdata0=%h rdata1=%h addr=%0d data=%h",
                               ifa.r0_rdata, ifa.r1_rdata, ifa.mem_address, ifa.mem_data);
        end
        @(negedge clk);
        rst_a = 1'b0;
        run_a(0, 1'b0, 6'd5, 32'h0, 0);
        model_a(0, 1'b0, 6'd5, 32'h0);
        n_tests++; if (obs_ready_n !== 3) begin n_fail++; $display("FAIL post_reset_ready_cycle: got %0d exp 3", obs_ready_n); end
        n_tests++; if (obs_rdata !== exp_rd[0]) begin n_fail++; $display("FAIL post_reset_rdata: got %h exp %h", obs_rdata, exp_rd[0]); end
    endtask

    task automatic test_contention();
        int            rdy_n [2];
        int            first, second, p;
        int            got_id[$];
        int            got_n[$];
        logic [AW-1:0] ra [2];
        rst_a = 1'b1; model_reset_a(); @(negedge clk); rst_a = 1'b0;
        ifa.r0_we = 1'b1; ifa.r0_addr = 6'd1; ifa.r0_wdata = 32'h11;
        ifa.r1_we = 1'b0; ifa.r1_addr = 6'd1; ifa.r1_wdata = 32'h0;
        ifa.r0_req = 1'b1; ifa.r1_req = 1'b1;
        rdy_n[0] = -1; rdy_n[1] = -1;
        for (int n = 1; n <= 2 * int'(WA) + 8; n++) begin
            @(negedge clk);
            if (ifa.r0_ready) begin rdy_n[0] = n; ifa.r0_req = 1'b0; end
            if (ifa.r1_ready) begin rdy_n[1] = n; ifa.r1_req = 1'b0; end
        end
        first = m_prio; second = 1 - first;
        if (first == 0) begin model_a(0, 1'b1, 6'd1, 32'h11); model_a(1, 1'b0, 6'd1, 32'h0); end
        else            begin model_a(1, 1'b0, 6'd1, 32'h0); model_a(0, 1'b1, 6'd1, 32'h11); end
        n_tests++; if (rdy_n[first] !== int'(WA) + 2) begin n_fail++; $display("FAIL contend_first: r%0d ready at %0d exp %0d", first, rdy_n[first], WA + 2); end
        n_tests++; if (rdy_n[second] !== 2 * int'(WA) + 5) begin n_fail++; $display("FAIL contend_second: r%0d ready at %0d exp %0d", second, rdy_n[second], 2 * WA + 5); end
        n_tests++; if (ifa.r1_rdata !== exp_rd[1]) begin n_fail++; $display("FAIL contend_r1_rdata: got %h exp %h", ifa.r1_rdata, exp_rd[1]); end

        // Both held continuously: grants must alternate.
        ra[0] = 6'($urandom_range(0, 63)); ra[1] = 6'($urandom_range(0, 63));
        ifa.r0_we = 1'b0; ifa.r0_addr = ra[0];
        ifa.r1_we = 1'b0; ifa.r1_addr = ra[1];
        ifa.r0_req = 1'b1; ifa.r1_req = 1'b1;
        for (int n = 1; n <= 3 * (int'(WA) + 3) + 2; n++) begin
            @(negedge clk);
            if (ifa.r0_ready) begin got_id.push_back(0); got_n.push_back(n); end
            if (ifa.r1_ready) begin got_id.push_back(1); got_n.push_back(n); end
            if (got_id.size() >= 3) begin ifa.r0_req = 1'b0; ifa.r1_req = 1'b0; end
        end
        n_tests++; if (got_id.size() !== 3) begin n_fail++; $display("FAIL alt_grant_count: got %0d exp 3", got_id.size()); end
        for (int k = 0; k < got_id.size() && k < 3; k++) begin
            p = m_prio;
            model_a(p, 1'b0, ra[p], 32'h0);
            n_tests++; if (got_id[k] !== p) begin n_fail++; $display("FAIL alt_grant_order[%0d]: got r%0d exp r%0d", k, got_id[k], p); end
            n_tests++; if (got_n[k] !== int'(WA) + 2 + k * (int'(WA) + 3)) begin n_fail++; $display("FAIL alt_grant_cycle[%0d]: got %0d exp %0d", k, got_n[k], WA + 2 + k * (WA + 3)); end
        end
        n_tests++; if (ifa.r0_rdata !== exp_rd[0] || ifa.r1_rdata !== exp_rd[1]) begin
            n_fail++; $display("FAIL alt_rdata: got %h/%h exp %h/%h", ifa.r0_rdata, ifa.r1_rdata, exp_rd[0], exp_rd[1]);
        end
    endtask

    task automatic test_early_deassert();
        run_a(1, 1'b1, 6'd7, 32'hA5A5A5A5, 1);
        model_a(1, 1'b1, 6'd7, 32'hA5A5A5A5);
        n_tests++; if (obs_ready_cnt !== 1) begin n_fail++; $display("FAIL early_ready_count: got %0d exp 1", obs_ready_cnt); end
        n_tests++; if (obs_ready_n !== int'(WA) + 2) begin n_fail++; $display("FAIL early_ready_cycle: got %0d exp %0d", obs_ready_n, WA + 2); end
        n_tests++; if (obs_wr_cnt !== 1) begin n_fail++; $display("FAIL early_wr_count: got %0d exp 1", obs_wr_cnt); end
        n_tests++; if (mem_a[7] !== exp_mem[7]) begin n_fail++; $display("FAIL early_commit: got %h exp %h", mem_a[7], exp_mem[7]); end
    endtask

    task automatic test_random();
        int            r;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        for (int i = 0; i < 24; i++) begin
            r    = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = 6'($urandom_range(0, 15));
            wd   = $urandom;
            run_a(r, we, addr, wd, 0);
            model_a(r, we, addr, wd);
            n_tests++; if (obs_ready_n !== int'(WA) + 2 || obs_ready_cnt !== 1) begin n_fail++; $display("FAIL rand_ready[%0d]: at %0d count %0d exp at %0d once", i, obs_ready_n, obs_ready_cnt, WA + 2); end
            n_tests++; if (obs_wr_cnt !== (we ? 1 : 0)) begin n_fail++; $display("FAIL rand_wr_count[%0d]: got %0d exp %0d", i, obs_wr_cnt, we ? 1 : 0); end
            n_tests++; if (obs_rdata !== exp_rd[r] || obs_other_rdata !== exp_rd[1 - r]) begin
                n_fail++; $display("FAIL rand_rdata[%0d]: r%0d got %h/%h exp %h/%h", i, r, obs_rdata, obs_other_rdata, exp_rd[r], exp_rd[1 - r]);
            end
            n_tests++; if (obs_other_cnt !== 0) begin n_fail++; $display("FAIL rand_other_ready[%0d]: got %0d exp 0", i, obs_other_cnt); end
            n_tests++; if (mem_a[addr] !== exp_mem[addr]) begin n_fail++; $display("FAIL rand_mem[%0d]: got %h exp %h", i, mem_a[addr], exp_mem[addr]); end
        end
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] v;
        int            rd_cnt, rdy_n, other_cnt;
        v = $urandom;
        ifb.r0_we = 1'b1; ifb.r0_addr = 6'd63; ifb.r0_wdata = v; ifb.r0_req = 1'b1;
        for (int n = 1; n <= int'(WB) + 5; n++) begin
            @(negedge clk);
            if (ifb.r0_ready) ifb.r0_req = 1'b0;
        end
        ifb.r1_we = 1'b0; ifb.r1_addr = 6'd63; ifb.r1_wdata = '0; ifb.r1_req = 1'b1;
        rd_cnt = 0; rdy_n = -1; other_cnt = 0;
        for (int n = 1; n <= int'(WB) + 5; n++) begin
            @(negedge clk);
            if (ifb.mem_read) rd_cnt++;
            if (ifb.r1_ready) begin rdy_n = n; ifb.r1_req = 1'b0; end
            if (ifb.r0_ready) other_cnt++;
        end
        n_tests++; if (rd_cnt !== int'(WB) + 1) begin n_fail++; $display("FAIL ws_read_cycles: got %0d exp %0d", rd_cnt, WB + 1); end
        n_tests++; if (rdy_n !== int'(WB) + 2) begin n_fail++; $display("FAIL ws_ready_cycle: got %0d exp %0d", rdy_n, WB + 2); end
        n_tests++; if (ifb.r1_rdata !== v) begin n_fail++; $display("FAIL ws_rdata: got %h exp %h", ifb.r1_rdata, v); end
        n_tests++; if (other_cnt !== 0 || ifb.r0_rdata !== '0) begin n_fail++; $display("FAIL ws_r0_untouched: ready %0d rdata %h exp 0/0", other_cnt, ifb.r0_rdata); end
    endtask

    task automatic test_reset_in_access();
        int wr_cnt, rdy_cnt, rdy_n;
        wr_cnt = 0; rdy_cnt = 0;
        ifc.r0_we = 1'b1; ifc.r0_addr = 6'd9; ifc.r0_wdata = 32'h1; ifc.r0_req = 1'b1;
        for (int n = 1; n <= int'(WC) + 6; n++) begin
            @(negedge clk);
            if (n == 2) begin rst_c = 1'b1; ifc.r0_req = 1'b0; #1; end
            if (ifc.mem_write) wr_cnt++;
            if (ifc.r0_ready || ifc.r1_ready) rdy_cnt++;
        end
        n_tests++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL rst_access_write: got %0d exp 0", wr_cnt); end
        n_tests++; if (rdy_cnt !== 0) begin n_fail++; $display("FAIL rst_access_ready: got %0d exp 0", rdy_cnt); end
        n_tests++; if (mem_c[9] !== '0 || ifc.mem_read !== 1'b0 || ifc.mem_address !== '0) begin
            n_fail++; $display("FAIL rst_access_state: mem %h rd %b addr %0d exp 0/0/0", mem_c[9], ifc.mem_read, ifc.mem_address);
        end
        rst_c = 1'b0;
        @(negedge clk);
        ifc.r0_we = 1'b0; ifc.r0_req = 1'b1; rdy_n = -1;
        for (int n = 1; n <= int'(WC) + 4; n++) begin
            @(negedge clk);
            if (ifc.r0_ready) begin rdy_n = n; ifc.r0_req = 1'b0; end
        end
        n_tests++; if (rdy_n !== int'(WC) + 2 || ifc.r0_rdata !== '0) begin
            n_fail++; $display("FAIL rst_access_recover: ready at %0d rdata %h exp %0d/0", rdy_n, ifc.r0_rdata, WC + 2);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.r0_req = 1'b0; ifa.r0_we = 1'b0; ifa.r0_addr = '0; ifa.r0_wdata = '0;
        ifa.r1_req = 1'b0; ifa.r1_we = 1'b0; ifa.r1_addr = '0; ifa.r1_wdata = '0;
        ifb.r0_req = 1'b0; ifb.r0_we = 1'b0; ifb.r0_addr = '0; ifb.r0_wdata = '0;
        ifb.r1_req = 1'b0; ifb.r1_we = 1'b0; ifb.r1_addr = '0; ifb.r1_wdata = '0;
        ifc.r0_req = 1'b0; ifc.r0_we = 1'b0; ifc.r0_addr = '0; ifc.r0_wdata = '0;
        ifc.r1_req = 1'b0; ifc.r1_we = 1'b0; ifc.r1_addr = '0; ifc.r1_wdata = '0;
        model_reset_a();
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        test_reset_values();
        test_write_read();
        test_reset();
        test_contention();
        test_early_deassert();
        test_random();
        test_wait_states();
        test_reset_in_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
